// File: rtl/mux_pkg.sv
// Shared types and constants for the mux path: arbiter states and select encoding.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Round-robin helper: the stream that gets priority after `s` finishes a packet.
  function automatic logic other_sel(input logic s);
    return ~s;
  endfunction

endpackage

// File: rtl/stream_arb_2x1_out_reg_slice.sv
// Registered valid/data/last output stage with a skid-free ready:
// a new beat is accepted whenever the register is empty or being drained.
module out_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Next-state: load a new beat, drain the held one, or keep holding it
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      last_d  = in_last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; data/last keep stale values while valid is low
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/stream_arb_2x1.sv
// Two-input round-robin packet arbiter feeding mux_2x1. The grant is taken in
// IDLE (one bubble cycle) and held until the granted stream's last beat is accepted.
module stream_arb_2x1
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              prio_q, prio_d;
  logic              sel_q, sel_d;
  logic              slice_ready;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_last;

  // Readies depend only on state and the output register, never on input valids
  assign a_ready = (state_q == LOCK_A) && slice_ready;
  assign b_ready = (state_q == LOCK_B) && slice_ready;
  assign busy    = (state_q != IDLE);
  assign sel     = sel_q;

  // Route the granted stream into the output slice; nothing passes in IDLE
  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    src_last  = 1'b0;
    case (state_q)
      LOCK_A: begin
        src_valid = a_valid;
        src_data  = a_data;
        src_last  = a_last;
      end
      LOCK_B: begin
        src_valid = b_valid;
        src_data  = b_data;
        src_last  = b_last;
      end
      default: ;
    endcase
  end

  // Grant decision in IDLE, release and priority flip on an accepted last beat
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || prio_q == SEL_A)) begin
          state_d = LOCK_A;
          sel_d   = SEL_A;
        end else if (b_valid) begin
          state_d = LOCK_B;
          sel_d   = SEL_B;
        end
      end
      LOCK_A: begin
        if (a_valid && a_ready && a_last) begin
          state_d = IDLE;
          prio_d  = other_sel(SEL_A);
        end
      end
      LOCK_B: begin
        if (b_valid && b_ready && b_last) begin
          state_d = IDLE;
          prio_d  = other_sel(SEL_B);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state, round-robin pointer and registered mux select
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= SEL_A;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
    end
  end

  out_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (src_valid),
    .in_data_i  (src_data),
    .in_last_i  (src_last),
    .in_ready_o (slice_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready)
  );

endmodule

// File: doc/stream_arb_2x1.md
Name: stream_arb_2x1

Overview:
- Two-input packet arbiter placed directly upstream of mux_2x1.
- Chooses between stream A and stream B using round-robin priority, and holds the grant until the end of the packet.
- Drives the mux select `sel` and presents the selected beats on one registered output stream with valid/ready handshake.
- Gives the mux stage a deterministic, packet-atomic select source.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- a_valid  in  1  stream A beat valid.
- a_data  in  DATA_W  stream A beat data.
- a_last  in  1  stream A final beat of packet.
- a_ready  out  1  stream A beat accepted when a_valid && a_ready.
- b_valid  in  1  stream B beat valid.
- b_data  in  DATA_W  stream B beat data.
- b_last  in  1  stream B final beat of packet.
- b_ready  out  1  stream B beat accepted when b_valid && b_ready.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_W  output beat data (registered).
- out_last  out  1  output final beat (registered).
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- sel  out  1  0 = A granted, 1 = B granted; feeds mux_2x1 sel.
- busy  out  1  high while a packet is locked.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, prio=A.
  - out_valid=0, out_data=0, out_last=0, sel=0, busy=0.
  - a_ready=0, b_ready=0.
  - Reset mid-packet drops the partial packet and any held output beat; no recovery.
- States: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - a_ready=b_ready=0.
  - Only A valid -> LOCK_A. Only B valid -> LOCK_B.
  - Both valid -> lock the stream named by prio.
  - Neither valid -> stay in IDLE.
  - sel is registered with the transition: 0 for LOCK_A, 1 for LOCK_B. In IDLE, sel holds its last value.
  - One bubble cycle per packet: the grant decision takes one cycle before any beat is accepted.
- LOCK_x:
  - x_ready = !out_valid || out_ready. The other ready is 0.
  - On x_valid && x_ready: out_data<=x_data, out_last<=x_last, out_valid<=1.
  - If that accepted beat has last=1, go to IDLE the next cycle and set prio to the other stream.
- Output register:
  - If out_valid && out_ready and no new beat is loaded, out_valid<=0.
  - When out_valid=0, out_data and out_last hold their old values; the value is don't-care.
  - Throughput is one beat per cycle inside a packet when out_ready stays high.
- busy = (state != IDLE).
- Boundary cases:
  - Single-beat packet (valid and last on the first beat): one beat, then back to IDLE.
  - Backpressure: out_ready=0 with out_valid=1 -> x_ready=0; out_data and out_last stay stable. Once asserted, out_valid does not drop until the beat is accepted.
  - The un-granted stream is never accepted, even if it asserts last.
  - prio changes only when a last beat is accepted. A lone requester wins regardless of prio.
  - A valid deasserted mid-packet keeps the lock, with no timeout.
- No combinational path from inputs to out_*. a_ready and b_ready depend combinationally on out_ready, out_valid and state only.

Decomposition:
- Shared package mux_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_t;
  - localparam SEL_A=1'b0 and SEL_B=1'b1.
- Sub-module out_reg_slice: holds the valid/data/last output register and its ready logic. It is reusable for other mux-path stages.
- The arbiter FSM stays in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold rst=1 for 2 cycles with all valids=1.
   - Required: every output is 0 and a_ready=b_ready=0. The cycle after release: busy=1, sel=0 (prio=A).
2. Contention round-robin:
   - Stimulus: A sends 2-beat packet 0x11,0x12(last). B sends 1-beat packet 0x21(last). Both valid from cycle 0. out_ready=1.
   - Required: output order 0x11, 0x12, 0x21. sel=0 during A's packet, then sel=1. out_last=1 on 0x12 and on 0x21. Next contention grants A.
3. Packet atomicity:
   - Stimulus: during A's 3-beat packet, B asserts b_valid with b_last=1.
   - Required: b_ready=0 throughout A's packet. B is granted only after A's last beat is accepted plus one IDLE cycle.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles while out_valid=1 and out_data=0x33.
   - Required: out_data stays 0x33, a_ready=0, and no beat is lost. When out_ready=1 the next beat follows in the next cycle.
5. Lone requester:
   - Stimulus: prio=B, only A valid with 0x44(last).
   - Required: A is granted, sel=0, 0x44 appears at the output, prio becomes B.
6. Reset mid-packet:
   - Stimulus: rst pulsed after the first beat of a B packet.
   - Required: state=IDLE, out_valid=0, sel=0. The next grant follows prio=A.
